// File: rtl/d_to_ex_pipe_ctl.sv
// Decode->execute pipeline register with valid/ready handshake, flush, load-use
// bubble insertion and a saturating count of inserted bubbles.
module d_to_ex_pipe_ctl #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            D_valid,
  output logic            D_ready,
  input  logic [XLEN-1:0] D_a,
  input  logic [XLEN-1:0] D_a2,
  input  logic [XLEN-1:0] D_b,
  input  logic [XLEN-1:0] D_b2,
  input  logic [OPW-1:0]  D_alu_op,
  input  logic [REGW-1:0] D_rd,
  input  logic            D_brn,
  input  logic            D_ld,
  input  logic            D_str,
  input  logic            D_we,
  input  logic [REGW-1:0] D_rs1,
  input  logic [REGW-1:0] D_rs2,
  input  logic            D_use_rs1,
  input  logic            D_use_rs2,
  input  logic            flush,
  input  logic            EX_ready,
  output logic            EX_valid,
  output logic [XLEN-1:0] EX_a,
  output logic [XLEN-1:0] EX_a2,
  output logic [XLEN-1:0] EX_b,
  output logic [XLEN-1:0] EX_b2,
  output logic [OPW-1:0]  EX_alu_op,
  output logic [REGW-1:0] EX_rd,
  output logic            EX_brn,
  output logic            EX_ld,
  output logic            EX_str,
  output logic            EX_we,
  output logic [CNTW-1:0] bubble_cnt
);

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_a2;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_b2;
  logic [OPW-1:0]  r_alu_op;
  logic [REGW-1:0] r_rd;
  // Control bits packed as {brn, ld, str, we}; cleared whenever the slot empties.
  logic [3:0]      r_ctrl;
  logic [CNTW-1:0] r_bubble_cnt;

  logic w_ex_free;
  logic w_src1_hit;
  logic w_src2_hit;
  logic w_hazard;

  // Slot availability, load-use detection and the combinational accept signal.
  always_comb begin
    w_src1_hit = D_use_rs1 && (D_rs1 == r_rd);
    w_src2_hit = D_use_rs2 && (D_rs2 == r_rd);
    w_hazard   = D_valid && r_valid && r_ctrl[2] && (r_rd != {REGW{1'b0}}) &&
                 (w_src1_hit || w_src2_hit);
    w_ex_free  = !r_valid || EX_ready;
    D_ready    = w_ex_free && !w_hazard && !flush;
  end

  // EX slot update: flush beats hold beats bubble beats load; data fields only change on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_a          <= {XLEN{1'b0}};
      r_a2         <= {XLEN{1'b0}};
      r_b          <= {XLEN{1'b0}};
      r_b2         <= {XLEN{1'b0}};
      r_alu_op     <= {OPW{1'b0}};
      r_rd         <= {REGW{1'b0}};
      r_ctrl       <= 4'b0000;
      r_bubble_cnt <= {CNTW{1'b0}};
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= 4'b0000;
    end else if (!w_ex_free) begin
      r_valid <= r_valid;
      r_ctrl  <= r_ctrl;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
      r_ctrl  <= 4'b0000;
      if (r_bubble_cnt != {CNTW{1'b1}}) begin
        r_bubble_cnt <= r_bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end else if (D_valid) begin
      r_valid  <= 1'b1;
      r_a      <= D_a;
      r_a2     <= D_a2;
      r_b      <= D_b;
      r_b2     <= D_b2;
      r_alu_op <= D_alu_op;
      r_rd     <= D_rd;
      r_ctrl   <= {D_brn, D_ld, D_str, D_we};
    end else begin
      r_valid <= 1'b0;
      r_ctrl  <= 4'b0000;
    end
  end

  assign EX_valid   = r_valid;
  assign EX_a       = r_a;
  assign EX_a2      = r_a2;
  assign EX_b       = r_b;
  assign EX_b2      = r_b2;
  assign EX_alu_op  = r_alu_op;
  assign EX_rd      = r_rd;
  assign EX_brn     = r_ctrl[3];
  assign EX_ld      = r_ctrl[2];
  assign EX_str     = r_ctrl[1];
  assign EX_we      = r_ctrl[0];
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_d_to_ex_pipe_ctl.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-level model.
module tb_d_to_ex_pipe_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        D_valid = 1'b0, D_brn = 1'b0, D_ld = 1'b0, D_str = 1'b0, D_we = 1'b0;
  logic [31:0] D_a = 32'd0, D_a2 = 32'd0, D_b = 32'd0, D_b2 = 32'd0;
  logic [3:0]  D_alu_op = 4'd0;
  logic [4:0]  D_rd = 5'd0, D_rs1 = 5'd0, D_rs2 = 5'd0;
  logic        D_use_rs1 = 1'b0, D_use_rs2 = 1'b0, flush = 1'b0, EX_ready = 1'b1;

  logic        D_ready, EX_valid, EX_brn, EX_ld, EX_str, EX_we;
  logic [31:0] EX_a, EX_a2, EX_b, EX_b2;
  logic [3:0]  EX_alu_op;
  logic [4:0]  EX_rd;
  logic [15:0] bubble_cnt;

  logic        x_ready, x_valid, x_brn, x_ld, x_str, x_we;
  logic [31:0] x_a, x_a2, x_b, x_b2;
  logic [3:0]  x_op;
  logic [4:0]  x_rd;
  logic [1:0]  x_cnt;

  d_to_ex_pipe_ctl dut (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid), .D_ready(D_ready),
    .D_a(D_a), .D_a2(D_a2), .D_b(D_b), .D_b2(D_b2), .D_alu_op(D_alu_op), .D_rd(D_rd),
    .D_brn(D_brn), .D_ld(D_ld), .D_str(D_str), .D_we(D_we),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
    .flush(flush), .EX_ready(EX_ready), .EX_valid(EX_valid),
    .EX_a(EX_a), .EX_a2(EX_a2), .EX_b(EX_b), .EX_b2(EX_b2), .EX_alu_op(EX_alu_op),
    .EX_rd(EX_rd), .EX_brn(EX_brn), .EX_ld(EX_ld), .EX_str(EX_str), .EX_we(EX_we),
    .bubble_cnt(bubble_cnt)
  );

  d_to_ex_pipe_ctl #(.CNTW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid), .D_ready(x_ready),
    .D_a(D_a), .D_a2(D_a2), .D_b(D_b), .D_b2(D_b2), .D_alu_op(D_alu_op), .D_rd(D_rd),
    .D_brn(D_brn), .D_ld(D_ld), .D_str(D_str), .D_we(D_we),
    .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
    .flush(flush), .EX_ready(EX_ready), .EX_valid(x_valid),
    .EX_a(x_a), .EX_a2(x_a2), .EX_b(x_b), .EX_b2(x_b2), .EX_alu_op(x_op),
    .EX_rd(x_rd), .EX_brn(x_brn), .EX_ld(x_ld), .EX_str(x_str), .EX_we(x_we),
    .bubble_cnt(x_cnt)
  );

  int total = 0;
  int bad = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: one instruction slot plus an unbounded bubble tally.
  typedef struct packed {
    logic [31:0] a, a2, b, b2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        brn, ld, st, we;
  } ins_t;

  logic    m_valid;
  ins_t    m_ins;
  longint  m_bubbles;

  function automatic logic m_hazard();
    if (!(D_valid && m_valid && m_ins.ld && m_ins.rd != 5'd0)) return 1'b0;
    return (D_use_rs1 && D_rs1 == m_ins.rd) || (D_use_rs2 && D_rs2 == m_ins.rd);
  endfunction

  function automatic logic m_ready();
    return (!m_valid || EX_ready) && !m_hazard() && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   = 1'b0;
      m_ins     = '0;
      m_bubbles = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (m_valid && !EX_ready) begin
      m_valid = m_valid;
    end else if (m_hazard()) begin
      m_valid = 1'b0;
      m_bubbles++;
    end else if (D_valid) begin
      m_valid = 1'b1;
      m_ins   = '{D_a, D_a2, D_b, D_b2, D_alu_op, D_rd, D_brn, D_ld, D_str, D_we};
    end else begin
      m_valid = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("d_ready", D_ready, m_ready());
      chk("ex_valid", EX_valid, m_valid);
      chk("ex_ctrl", {EX_brn, EX_ld, EX_str, EX_we},
          m_valid ? {m_ins.brn, m_ins.ld, m_ins.st, m_ins.we} : 4'd0);
      chk("bubble_cnt", bubble_cnt, (m_bubbles > 65535) ? 65535 : m_bubbles);
      chk("bubble_cnt2", x_cnt, (m_bubbles > 3) ? 3 : m_bubbles);
      if (m_valid) begin
        chk("ex_data", {EX_a, EX_a2, EX_b, EX_b2, EX_alu_op, EX_rd},
            {m_ins.a, m_ins.a2, m_ins.b, m_ins.b2, m_ins.op, m_ins.rd});
      end
    end
  end

  task automatic put(input logic v, input logic [31:0] a, input logic [4:0] rd,
                     input logic ld, input logic [4:0] rs1, input logic u1);
    D_valid = v;  D_a = a;  D_a2 = ~a;  D_b = a + 32'd100;  D_b2 = {a[15:0], a[31:16]};
    D_alu_op = a[3:0];  D_rd = rd;  D_ld = ld;  D_brn = a[0];
    D_str = !ld && a[1];  D_we = ld || a[2];
    D_rs1 = rs1;  D_use_rs1 = u1;  D_rs2 = 5'd0;  D_use_rs2 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp6 [5] = '{1, 2, 3, 3, 3};
    logic hold;
    #3;
    chk("rst_valid", EX_valid, 0);
    chk("rst_cnt", bubble_cnt, 0);
    chk("rst_a", EX_a, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Saturation on the narrow counter: 5 load-use bubbles.
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 32'd100 + i, 5'd3, 1'b1, 5'd0, 1'b0); cyc();
      put(1'b1, 32'd200 + i, 5'd4, 1'b0, 5'd3, 1'b1); cyc();
      chk("sat_cnt2", x_cnt, exp6[i]);
      chk("sat_cnt", bubble_cnt, i + 1);
      cyc();
      chk("sat_dep", EX_a, 200 + i);
    end

    // Asynchronous reset between edges with a load sitting in EX.
    put(1'b1, 32'd90, 5'd9, 1'b1, 5'd0, 1'b0); cyc();
    put(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("pre_rst_ld", EX_ld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", EX_valid, 0);
    chk("arst_ld", EX_ld, 0);
    chk("arst_a", EX_a, 0);
    chk("arst_rd", EX_rd, 0);
    chk("arst_cnt", bubble_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Streaming at full rate.
    for (int k = 1; k <= 4; k++) begin
      put(1'b1, k, 5'd1, 1'b0, 5'd0, 1'b0);
      #1 chk("strm_rdy", D_ready, 1);
      cyc();
      chk("strm_a", EX_a, k);
      chk("strm_valid", EX_valid, 1);
    end

    // Load-use hazard, then the rd=0 and use_rs1=0 non-hazards.
    put(1'b1, 32'd10, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    put(1'b1, 32'd20, 5'd6, 1'b0, 5'd5, 1'b1);
    #1 chk("lu_rdy", D_ready, 0);
    cyc();
    chk("lu_bubble", EX_valid, 0);
    chk("lu_cnt", bubble_cnt, 1);
    cyc();
    chk("lu_dep", EX_a, 20);
    chk("lu_dep_v", EX_valid, 1);
    put(1'b1, 32'd30, 5'd0, 1'b1, 5'd0, 1'b0); cyc();
    put(1'b1, 32'd40, 5'd7, 1'b0, 5'd0, 1'b1);
    #1 chk("rd0_rdy", D_ready, 1);
    cyc();
    chk("rd0_a", EX_a, 40);
    put(1'b1, 32'd50, 5'd5, 1'b1, 5'd0, 1'b0); cyc();
    put(1'b1, 32'd60, 5'd8, 1'b0, 5'd5, 1'b0);
    #1 chk("nouse_rdy", D_ready, 1);
    cyc();
    chk("nouse_a", EX_a, 60);
    chk("nouse_cnt", bubble_cnt, 1);

    // Stall for 3 cycles, then release.
    EX_ready = 1'b0;
    put(1'b1, 32'd70, 5'd9, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_rdy", D_ready, 0);
      cyc();
      chk("stall_a", EX_a, 60);
      chk("stall_v", EX_valid, 1);
    end
    EX_ready = 1'b1;
    #1 chk("rel_rdy", D_ready, 1);
    cyc();
    chk("rel_a", EX_a, 70);

    // Flush kills both slots; D payload with we/str set must never appear.
    put(1'b1, 32'd6, 5'd11, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    #1 chk("fl_rdy", D_ready, 0);
    cyc();
    flush = 1'b0;
    put(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("fl_valid", EX_valid, 0);
    chk("fl_we", EX_we, 0);
    chk("fl_str", EX_str, 0);
    chk("fl_a", EX_a, 70);
    cyc();
    chk("fl_idle", EX_valid, 0);

    // Random traffic; payload held while offered but not accepted.
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        put($urandom_range(0, 9) < 8, $urandom, 5'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 1'($urandom));
        D_rs2 = 5'($urandom_range(0, 3));
        D_use_rs2 = 1'($urandom);
      end
      EX_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      #1 hold = D_valid && !D_ready;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
